tmds_multi_encoder: RTL

Parametrised, pipelined TMDS encoder for NUM_CH channels, the next generation of the single-channel DVI pixel encoder. Each channel supports four modes: video (8b/10b transition-minimised, DC-balanced), control (2-bit), TERC4 data-island (4-bit), and video guard band. This makes the block usable for HDMI-style output as well as plain DVI. It sits between the video timing/packet mux and the 10:1 serialisers, clocked at the pixel clock.

---
 rtl/tmds_pkg.sv | 80 ++++++++
 rtl/tmds_channel.sv | 101 ++++++++++
 rtl/tmds_multi_encoder.sv | 34 +++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared types, symbol tables and helpers for the multi-channel TMDS encoder.
package tmds_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        MODE_CTRL   = 2'd0,
        MODE_VIDEO  = 2'd1,
        MODE_TERC4  = 2'd2,
        MODE_VGUARD = 2'd3
    } mode_e;

    localparam logic [9:0] CTRL_CODE_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_CODE_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_CODE_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_CODE_11 = 10'b1010101011;

    // Guard band: GUARD_CODE_B on channels with index mod 3 == 1, GUARD_CODE_A elsewhere.
    localparam logic [9:0] GUARD_CODE_A = 10'b1011001100;
    localparam logic [9:0] GUARD_CODE_B = 10'b0100110011;

    function automatic logic [9:0] terc4_code(input logic [3:0] nib);
        logic [9:0] code;
        case (nib)
            4'd0:    code = 10'b1010011100;
            4'd1:    code = 10'b1001100011;
            4'd2:    code = 10'b1011100100;
            4'd3:    code = 10'b1011100010;
            4'd4:    code = 10'b0101110001;
            4'd5:    code = 10'b0100011110;
            4'd6:    code = 10'b0110001110;
            4'd7:    code = 10'b0100111100;
            4'd8:    code = 10'b1011001100;
            4'd9:    code = 10'b0100111001;
            4'd10:   code = 10'b0110011100;
            4'd11:   code = 10'b1011000110;
            4'd12:   code = 10'b1010001110;
            4'd13:   code = 10'b1001110001;
            4'd14:   code = 10'b0101100011;
            default: code = 10'b1011000011;
        endcase
        return code;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] code;
        case (c)
            2'b00:   code = CTRL_CODE_00;
            2'b01:   code = CTRL_CODE_01;
            2'b10:   code = CTRL_CODE_10;
            default: code = CTRL_CODE_11;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising first stage; bit 8 flags XOR (1) versus XNOR (0) chaining.
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(d[i] ^ q[i-1]) : (d[i] ^ q[i-1]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: stage 1 transition-minimises the byte, stage 2 balances DC
// (or emits a fixed control/TERC4/guard symbol) and keeps the running disparity.
module tmds_channel
    import tmds_pkg::*;
#(
    parameter int CH_IDX            = 0,
    parameter int RESET_CNT_ON_CTRL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [7:0]       data,
    input  logic [1:0]       ctrl,
    input  logic [3:0]       aux,
    output logic [9:0]       encoded,
    output logic [CNT_W-1:0] disparity
);

    logic [8:0]              r_qm;
    mode_e                   r_mode;
    logic [1:0]              r_ctrl;
    logic [3:0]              r_aux;
    logic [9:0]              r_encoded;
    logic signed [CNT_W-1:0] r_cnt;

    logic [3:0]              w_n1;
    logic signed [CNT_W-1:0] w_diff;
    logic signed [CNT_W-1:0] w_two_q8;
    logic signed [CNT_W-1:0] w_two_nq8;
    logic signed [CNT_W-1:0] w_cnt_idle;
    logic                    w_cnt_pos;
    logic                    w_cnt_neg;
    logic                    w_diff_pos;
    logic                    w_diff_neg;
    logic [9:0]              w_code_next;
    logic signed [CNT_W-1:0] w_cnt_next;

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values and the two stages shift together on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qm   <= '0;
            r_mode <= MODE_CTRL;
            r_ctrl <= 2'b00;
            r_aux  <= '0;
        end else begin
            r_qm   <= tmds_qm(data);
            r_mode <= mode_e'(mode);
            r_ctrl <= ctrl;
            r_aux  <= aux;
        end
    end

    // N1 - N0 of q_m[7:0] equals 2*N1 - 8; the 5-bit wrap is exact over -8..+8.
    assign w_n1       = ones8(r_qm[7:0]);
    assign w_diff     = CNT_W'({w_n1, 1'b0}) - CNT_W'(8);
    assign w_two_q8   = {{(CNT_W-2){1'b0}},  r_qm[8], 1'b0};
    assign w_two_nq8  = {{(CNT_W-2){1'b0}}, ~r_qm[8], 1'b0};
    assign w_cnt_neg  = r_cnt[CNT_W-1];
    assign w_cnt_pos  = !r_cnt[CNT_W-1] && (r_cnt != '0);
    assign w_diff_neg = w_diff[CNT_W-1];
    assign w_diff_pos = !w_diff[CNT_W-1] && (w_diff != '0);
    assign w_cnt_idle = (RESET_CNT_ON_CTRL != 0) ? '0 : r_cnt;

    // NOTE: both outputs get a default first so no path through the case infers a latch.
    always_comb begin
        w_code_next = CTRL_CODE_00;
        w_cnt_next  = w_cnt_idle;
        case (r_mode)
            MODE_VIDEO: begin
                if ((r_cnt == '0) || (w_diff == '0)) begin
                    w_code_next = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                    w_cnt_next  = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
                end else if ((w_cnt_pos && w_diff_pos) || (w_cnt_neg && w_diff_neg)) begin
                    w_code_next = {1'b1, r_qm[8], ~r_qm[7:0]};
                    w_cnt_next  = r_cnt + w_two_q8 - w_diff;
                end else begin
                    w_code_next = {1'b0, r_qm[8], r_qm[7:0]};
                    w_cnt_next  = r_cnt - w_two_nq8 + w_diff;
                end
            end
            MODE_TERC4:  w_code_next = terc4_code(r_aux);
            MODE_VGUARD: w_code_next = ((CH_IDX % 3) == 1) ? GUARD_CODE_B : GUARD_CODE_A;
            default:     w_code_next = ctrl_code(r_ctrl);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_encoded <= CTRL_CODE_00;
            r_cnt     <= '0;
        end else begin
            r_encoded <= w_code_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign encoded   = r_encoded;
    assign disparity = r_cnt;

endmodule

// File: rtl/tmds_multi_encoder.sv
// NUM_CH-channel TMDS encoder: one tmds_channel per lane, sharing only the mode input.
module tmds_multi_encoder
    import tmds_pkg::*;
#(
    parameter int NUM_CH            = 3,
    parameter int RESET_CNT_ON_CTRL = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic [8*NUM_CH-1:0]     data,
    input  logic [2*NUM_CH-1:0]     ctrl,
    input  logic [4*NUM_CH-1:0]     aux,
    output logic [10*NUM_CH-1:0]    encoded,
    output logic [CNT_W*NUM_CH-1:0] disparity
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tmds_channel #(
            .CH_IDX            (k),
            .RESET_CNT_ON_CTRL (RESET_CNT_ON_CTRL)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .mode      (mode),
            .data      (data[8*k +: 8]),
            .ctrl      (ctrl[2*k +: 2]),
            .aux       (aux[4*k +: 4]),
            .encoded   (encoded[10*k +: 10]),
            .disparity (disparity[CNT_W*k +: CNT_W])
        );
    end

endmodule
